// File: rtl/load_stall_controller.sv
// Load-use stall controller: turns a hazard pulse into a bounded pipeline freeze
// (PC and IF/ID held, ID/EX bubbled) and keeps saturating stall statistics.
module load_stall_controller #(
  parameter int unsigned STALL_MAX   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter logic [5:0]  OPCODE_LW_P = 6'b100011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_hazard_signal,
  input  logic [5:0]       opcode_step4,
  input  logic             branch_flush,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic             stall_active,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_events
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(STALL_MAX - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       w_next_wait;
  logic             w_enter;
  logic             w_timeout;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_bubble;
  logic             r_stall_active;
  logic             r_stall_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_hazard_events;

  always_comb begin
    w_next_state = RUN;
    w_next_wait  = '0;
    w_enter      = 1'b0;
    w_timeout    = 1'b0;
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_bubble     = 1'b0;
    if (reset) begin
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
      w_bubble  = 1'b1;
    end else if (branch_flush) begin
      w_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (load_hazard_signal) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_bubble     = 1'b1;
            w_next_state = STALL;
            w_enter      = 1'b1;
          end
        end
        STALL: begin
          // Load completion wins over timeout; a hazard seen here is dropped.
          if (opcode_step4 == OPCODE_LW_P) begin
            w_next_state = RUN;
          end else if (r_wait_cnt >= LP_WAIT_LAST) begin
            w_timeout = 1'b1;
          end else begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_bubble     = 1'b1;
            w_next_state = STALL;
            w_next_wait  = r_wait_cnt + 4'd1;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= RUN;
      r_wait_cnt      <= '0;
      r_stall_active  <= 1'b0;
      r_stall_timeout <= 1'b0;
      r_stall_cycles  <= '0;
      r_hazard_events <= '0;
    end else begin
      r_state        <= w_next_state;
      r_wait_cnt     <= w_next_wait;
      r_stall_active <= (w_next_state == STALL);
      if (w_timeout) begin
        r_stall_timeout <= 1'b1;
      end
      if (!w_pc_we && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_enter && (r_hazard_events != '1)) begin
        r_hazard_events <= r_hazard_events + CNT_W'(1);
      end
    end
  end

  assign pc_write_en   = w_pc_we;
  assign ifid_write_en = w_ifid_we;
  assign idex_bubble   = w_bubble;
  assign stall_active  = r_stall_active;
  assign stall_timeout = r_stall_timeout;
  assign stall_cycles  = r_stall_cycles;
  assign hazard_events = r_hazard_events;

endmodule

// File: tb/tb_load_stall_controller.sv
// Scoreboard bench for load_stall_controller: directed hazard scenarios followed by
// random traffic, checked against a frozen-cycle-count reference model.
module tb_load_stall_controller;

  localparam int unsigned STALL_MAX = 4;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned SAT       = (1 << CNT_W) - 1;
  localparam logic [5:0]  LW        = 6'b100011;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_hazard_signal;
  logic [5:0]       opcode_step4;
  logic             branch_flush;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             idex_bubble;
  logic             stall_active;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] hazard_events;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        act;
    logic        tmo;
    int unsigned scyc;
    int unsigned hev;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: an episode is a run of consecutive frozen cycles starting at the hazard.
  bit          m_stall;
  int unsigned m_frozen;
  int unsigned m_scyc;
  int unsigned m_hev;
  bit          m_tmo;

  load_stall_controller #(
    .STALL_MAX  (STALL_MAX),
    .CNT_W      (CNT_W),
    .OPCODE_LW_P(LW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .load_hazard_signal(load_hazard_signal),
    .opcode_step4      (opcode_step4),
    .branch_flush      (branch_flush),
    .pc_write_en       (pc_write_en),
    .ifid_write_en     (ifid_write_en),
    .idex_bubble       (idex_bubble),
    .stall_active      (stall_active),
    .stall_timeout     (stall_timeout),
    .stall_cycles      (stall_cycles),
    .hazard_events     (hazard_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit hz, input bit fl, input logic [5:0] op);
    exp_t e;
    bit   frz;
    @(posedge clk);
    #1;
    reset              = rst;
    load_hazard_signal = hz;
    branch_flush       = fl;
    opcode_step4       = op;
    if (rst) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
      e.act = 1'b0; e.tmo = 1'b0; e.scyc = 0; e.hev = 0;
      m_stall = 0; m_frozen = 0; m_scyc = 0; m_hev = 0; m_tmo = 0;
    end else begin
      e.act  = m_stall;
      e.tmo  = m_tmo;
      e.scyc = m_scyc;
      e.hev  = m_hev;
      frz    = 0;
      if (fl) begin
        m_stall = 0;
      end else if (!m_stall) begin
        if (hz) begin
          frz      = 1;
          m_stall  = 1;
          m_frozen = 1;
          if (m_hev < SAT) m_hev++;
        end
      end else if (op == LW) begin
        m_stall = 0;
      end else if (m_frozen == STALL_MAX) begin
        m_stall = 0;
        m_tmo   = 1;
      end else begin
        frz = 1;
        m_frozen++;
      end
      e.pc   = !frz;
      e.ifid = !frz;
      e.bub  = frz || fl;
      if (frz && m_scyc < SAT) m_scyc++;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("pc_write_en",   32'(pc_write_en),   32'(mon_e.pc));
      check("ifid_write_en", 32'(ifid_write_en), 32'(mon_e.ifid));
      check("idex_bubble",   32'(idex_bubble),   32'(mon_e.bub));
      check("stall_active",  32'(stall_active),  32'(mon_e.act));
      check("stall_timeout", 32'(stall_timeout), 32'(mon_e.tmo));
      check("stall_cycles",  32'(stall_cycles),  mon_e.scyc);
      check("hazard_events", 32'(hazard_events), mon_e.hev);
    end
  end

  logic [5:0] r_op;

  initial begin
    reset              = 1'b1;
    load_hazard_signal = 1'b0;
    branch_flush       = 1'b0;
    opcode_step4       = 6'd0;

    cyc(1, 0, 0, 6'd0);
    cyc(1, 0, 0, 6'd0);
    repeat (3) cyc(0, 0, 0, 6'd0);

    // load-use resolved two cycles after the hazard
    cyc(0, 1, 0, 6'd0);
    cyc(0, 0, 0, 6'd0);
    cyc(0, 0, 0, LW);
    repeat (2) cyc(0, 0, 0, 6'd0);

    // timeout: the load never shows up in step4
    cyc(0, 1, 0, 6'd0);
    repeat (6) cyc(0, 0, 0, 6'h2b);

    // flush during a stall, then hazard and flush together in RUN
    cyc(0, 1, 0, 6'd0);
    cyc(0, 0, 1, 6'd0);
    cyc(0, 0, 0, 6'd0);
    cyc(0, 1, 1, 6'd0);
    repeat (2) cyc(0, 0, 0, 6'd0);

    // hazard ignored on the completing cycle
    cyc(0, 1, 0, 6'd0);
    cyc(0, 1, 0, LW);
    cyc(0, 0, 0, 6'd0);

    // reset asserted between edges in the middle of a stall
    cyc(0, 1, 0, 6'd0);
    cyc(0, 0, 0, 6'd0);
    cyc(1, 0, 0, 6'd0);
    cyc(0, 0, 0, 6'd0);

    for (int i = 0; i < 2000; i++) begin
      r_op = ($urandom_range(0, 4) == 0) ? LW : 6'($urandom_range(0, 63));
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0),
          r_op);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_stall_controller.md
Name: load_stall_controller

Overview:
- Consumer and responder for `load_hazard_signal` from the load-use hazard detector.
- Turns a hazard pulse into a controlled pipeline freeze:
  - holds PC and the step1 (IF/ID) register;
  - injects a bubble into step2 (ID/EX);
  - releases when the load reaches step4, or when the stall timeout expires.
- Also tracks stall statistics for performance debug.
- Sits between the hazard detector and the PC / pipeline-register enables in the pipeline top.

Parameters:
- STALL_MAX, 4, maximum cycles spent in STALL before a forced release (valid range 1..15).
- CNT_W, 16, width of the saturating performance counters.
- OPCODE_LW_P, 6'b100011, load opcode compared against `opcode_step4` (same encoding as `OPCODE_LW`).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_hazard_signal  in  1  stall request from the hazard detector.
- opcode_step4  in  6  opcode currently in pipeline step4.
- branch_flush  in  1  taken-branch flush request from the branch unit.
- pc_write_en  out  1  PC register load enable.
- ifid_write_en  out  1  step1 pipeline register load enable.
- idex_bubble  out  1  forces step2 control signals to NOP.
- stall_active  out  1  high while the controller is in STALL (registered).
- stall_timeout  out  1  sticky flag: a stall was force-released by timeout.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0.
- hazard_events  out  CNT_W  saturating count of RUN->STALL entries.

Behaviour:
- States: RUN=2'b00, STALL=2'b01; encodings 2'b10/2'b11 are illegal and recover to RUN on the next edge.
- Internal `wait_cnt`: 4 bits.
- Reset (asynchronous, while high): state=RUN, wait_cnt=0, stall_active=0, stall_timeout=0, stall_cycles=0, hazard_events=0.
  - Forced outputs during reset: pc_write_en=0, ifid_write_en=0, idex_bubble=1 (pipeline frozen).
  - Reset asserted mid-STALL abandons the stall immediately; no counter update.
- Enable outputs are combinational (Mealy) from state and inputs, so a stall takes effect in the same cycle the hazard is raised.
- RUN, no hazard: pc_write_en=1, ifid_write_en=1, idex_bubble=0; stay in RUN.
- RUN, load_hazard_signal=1:
  - Same cycle: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
  - Next edge: STALL, wait_cnt=0, hazard_events+1.
- STALL, opcode_step4==OPCODE_LW_P (load completed):
  - Same cycle: pc_write_en=1, ifid_write_en=1, idex_bubble=0.
  - Next edge: RUN.
  - load_hazard_signal is ignored in this cycle; a new hazard is honoured only from RUN.
- STALL, no completion, wait_cnt < STALL_MAX-1: outputs frozen (0,0,1); wait_cnt+1 on the edge.
- STALL, no completion, wait_cnt == STALL_MAX-1:
  - Same cycle: outputs released (1,1,0).
  - Next edge: RUN, stall_timeout set to 1 (stays set until reset).
- branch_flush=1 (any state) has top priority:
  - Same cycle: pc_write_en=1, ifid_write_en=1, idex_bubble=1.
  - Next edge: RUN, wait_cnt=0.
  - Not counted in hazard_events, even if load_hazard_signal is also high.
- stall_active: registered; equals (state==STALL).
- stall_cycles: +1 on each edge where pc_write_en==0 and reset is low; saturates at all-ones.
- hazard_events: saturates at all-ones.
- Stall length: hazard in cycle N with load reaching step4 in cycle N+k gives exactly k frozen cycles (N..N+k-1); PC advances at the end of cycle N+k.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, release, inputs 0.
  - Response: during reset pc_write_en=0, idex_bubble=1. After release pc_write_en=1, ifid_write_en=1, idex_bubble=0, stall_cycles=0.
- Normal load-use:
  - Stimulus: hazard=1 in cycle 5 only; opcode_step4=6'b100011 in cycle 7.
  - Response: pc_write_en=0 in cycles 5-6, 1 in cycle 7; stall_active=1 in cycles 6-7; stall_cycles=2, hazard_events=1, stall_timeout=0.
- Timeout (STALL_MAX=4):
  - Stimulus: hazard in cycle 3; opcode_step4 never LW.
  - Response: pc_write_en=0 in cycles 3-6, 1 in cycle 7; stall_timeout=1 from cycle 8 and stays set; stall_cycles=4.
- Flush priority:
  - Stimulus: hazard in cycle 2; branch_flush=1 in cycle 3.
  - Response: cycle 3 gives (1,1,1); RUN in cycle 4; hazard_events=1.
- Simultaneous hazard and flush in RUN:
  - Response: (1,1,1), state stays RUN, hazard_events unchanged.
- Async reset mid-stall:
  - Stimulus: assert reset between edges during STALL.
  - Response: stall_active=0 and counters=0 immediately, without waiting for a clock edge.
